// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix arithmetic unit: operation codes, FSM states,
// default geometry and the row-major element offset helper.
package matrix_pkg;

   localparam int DEF_MAX_DIM    = 5;
   localparam int DEF_ELEM_WIDTH = 8;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_MUL = 2'b10;
   localparam logic [1:0] MODE_TRN = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit offset of element (row, col) in a flattened row-major matrix.
   function automatic int elem_offset(input int row, input int col,
                                      input int max_dim, input int elem_width);
      return (row * max_dim + col) * elem_width;
   endfunction

endpackage

// File: rtl/matrix_arith_unit_if.sv
// Request/result bundle of the matrix arithmetic unit; master drives the request,
// slave (the unit) drives results and status.
interface matrix_arith_unit_if
   import matrix_pkg::*;
#(
   parameter int MAX_DIM    = DEF_MAX_DIM,
   parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
);
   localparam int DW = $clog2(MAX_DIM + 1);
   localparam int MW = MAX_DIM * MAX_DIM * ELEM_WIDTH;

   logic                  start;
   logic [1:0]            mode;
   logic [DW-1:0]         m;
   logic [DW-1:0]         n;
   logic [ELEM_WIDTH-1:0] scalar;
   logic [MW-1:0]         matrixA_in;
   logic [MW-1:0]         matrixB_in;
   logic [MW-1:0]         matrix_out;
   logic [DW-1:0]         out_m;
   logic [DW-1:0]         out_n;
   logic                  busy;
   logic                  valid;
   logic                  err;

   modport master (
      output start, mode, m, n, scalar, matrixA_in, matrixB_in,
      input  matrix_out, out_m, out_n, busy, valid, err
   );

   modport slave (
      input  start, mode, m, n, scalar, matrixA_in, matrixB_in,
      output matrix_out, out_m, out_n, busy, valid, err
   );

endinterface

// File: rtl/matrix_elem_alu.sv
// Combinational per-element operation. Define MATRIX_SAT_EN for unsigned
// saturation; otherwise results wrap modulo 2^ELEM_WIDTH.
module matrix_elem_alu
   import matrix_pkg::*;
#(
   parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
) (
   input  logic [1:0]            mode,
   input  logic [ELEM_WIDTH-1:0] a,
   input  logic [ELEM_WIDTH-1:0] b,
   input  logic [ELEM_WIDTH-1:0] scalar,
   output logic [ELEM_WIDTH-1:0] res
);
   localparam int EW = ELEM_WIDTH;

`ifdef MATRIX_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [EW-1:0] ALL_ONES = '1;

   logic [EW:0]     sum;
   logic [EW:0]     diff;
   logic [2*EW-1:0] prod;

   // One extra bit on add/sub exposes carry and borrow for the clamp decision.
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      prod = {{EW{1'b0}}, a} * {{EW{1'b0}}, scalar};
      res  = a;
      case (mode)
         MODE_ADD: res = (SAT_EN && sum[EW])  ? ALL_ONES : sum[EW-1:0];
         MODE_SUB: res = (SAT_EN && diff[EW]) ? '0       : diff[EW-1:0];
         MODE_MUL: res = (SAT_EN && (|prod[2*EW-1:EW])) ? ALL_ONES : prod[EW-1:0];
         default:  res = a;
      endcase
   end

endmodule

// File: rtl/matrix_arith_unit.sv
// Sequential matrix engine: one element per cycle through matrix_elem_alu.
// Arithmetic saturation is selected by the MATRIX_SAT_EN macro inside the ALU.
module matrix_arith_unit
   import matrix_pkg::*;
#(
   parameter int MAX_DIM    = DEF_MAX_DIM,
   parameter int ELEM_WIDTH = DEF_ELEM_WIDTH
) (
   input logic                clk,
   input logic                reset,
   matrix_arith_unit_if.slave bus
);
   localparam int DW = $clog2(MAX_DIM + 1);
   localparam int MW = MAX_DIM * MAX_DIM * ELEM_WIDTH;
   localparam logic [DW-1:0] DIM_MAX = DW'(MAX_DIM);
   localparam logic [DW-1:0] DIM_ONE = DW'(1);

   state_t                state_q, state_d;
   logic [DW-1:0]         m_q, m_d;
   logic [DW-1:0]         n_q, n_d;
   logic [1:0]            mode_q, mode_d;
   logic [ELEM_WIDTH-1:0] scalar_q, scalar_d;
   logic [MW-1:0]         a_q, a_d;
   logic [MW-1:0]         b_q, b_d;
   logic [MW-1:0]         buf_q, buf_d;
   logic [MW-1:0]         out_q, out_d;
   logic [DW-1:0]         out_m_q, out_m_d;
   logic [DW-1:0]         out_n_q, out_n_d;
   logic [DW-1:0]         i_q, i_d;
   logic [DW-1:0]         j_q, j_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;

   logic [ELEM_WIDTH-1:0] elem_a;
   logic [ELEM_WIDTH-1:0] elem_b;
   logic [ELEM_WIDTH-1:0] elem_res;
   int                    rd_off;
   int                    wr_off;
   logic                  dims_ok;
   logic                  last_elem;

   // Transpose writes the source element (i,j) into slot (j,i).
   always_comb begin
      rd_off = elem_offset(int'(i_q), int'(j_q), MAX_DIM, ELEM_WIDTH);
      wr_off = (mode_q == MODE_TRN) ? elem_offset(int'(j_q), int'(i_q), MAX_DIM, ELEM_WIDTH)
                                    : rd_off;
      elem_a = a_q[rd_off +: ELEM_WIDTH];
      elem_b = b_q[rd_off +: ELEM_WIDTH];
   end

   matrix_elem_alu #(
      .ELEM_WIDTH (ELEM_WIDTH)
   ) u_elem_alu (
      .mode   (mode_q),
      .a      (elem_a),
      .b      (elem_b),
      .scalar (scalar_q),
      .res    (elem_res)
   );

   assign dims_ok   = (bus.m != '0) && (bus.m <= DIM_MAX) &&
                      (bus.n != '0) && (bus.n <= DIM_MAX);
   assign last_elem = (i_q == m_q - DIM_ONE) && (j_q == n_q - DIM_ONE);

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      n_d      = n_q;
      mode_d   = mode_q;
      scalar_d = scalar_q;
      a_d      = a_q;
      b_d      = b_q;
      buf_d    = buf_q;
      out_d    = out_q;
      out_m_d  = out_m_q;
      out_n_d  = out_n_q;
      i_d      = i_q;
      j_d      = j_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (dims_ok) begin
                  m_d      = bus.m;
                  n_d      = bus.n;
                  mode_d   = bus.mode;
                  scalar_d = bus.scalar;
                  a_d      = bus.matrixA_in;
                  b_d      = bus.matrixB_in;
                  buf_d    = '0;
                  i_d      = '0;
                  j_d      = '0;
                  busy_d   = 1'b1;
                  state_d  = ST_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_RUN: begin
            buf_d[wr_off +: ELEM_WIDTH] = elem_res;
            if (last_elem) begin
               // Publish on this edge so valid and matrix_out line up in DONE.
               out_d   = buf_d;
               out_m_d = (mode_q == MODE_TRN) ? n_q : m_q;
               out_n_d = (mode_q == MODE_TRN) ? m_q : n_q;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               i_d     = '0;
               j_d     = '0;
               state_d = ST_DONE;
            end else if (j_q == n_q - DIM_ONE) begin
               j_d = '0;
               i_d = i_q + DIM_ONE;
            end else begin
               j_d = j_q + DIM_ONE;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         m_q      <= '0;
         n_q      <= '0;
         mode_q   <= '0;
         scalar_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         buf_q    <= '0;
         out_q    <= '0;
         out_m_q  <= '0;
         out_n_q  <= '0;
         i_q      <= '0;
         j_q      <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         n_q      <= n_d;
         mode_q   <= mode_d;
         scalar_q <= scalar_d;
         a_q      <= a_d;
         b_q      <= b_d;
         buf_q    <= buf_d;
         out_q    <= out_d;
         out_m_q  <= out_m_d;
         out_n_q  <= out_n_d;
         i_q      <= i_d;
         j_q      <= j_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign bus.matrix_out = out_q;
   assign bus.out_m      = out_m_q;
   assign bus.out_n      = out_n_q;
   assign bus.busy       = busy_q;
   assign bus.valid      = valid_q;
   assign bus.err        = err_q;

endmodule

// File: doc/matrix_arith_unit.md
MATRIX_ARITH_UNIT -- requirements
Module: matrix_arith_unit

Interface
REQ-001 SHALL have parameter MAX_DIM, default 5, maximum rows/columns.
REQ-002 SHALL have parameter ELEM_WIDTH, default 8, unsigned element width in bits.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  operation: 00 A+B, 01 A-B, 10 A*scalar, 11 transpose(A).
- m  in  DW  rows of A, where DW = $clog2(MAX_DIM+1).
- n  in  DW  columns of A.
- scalar  in  ELEM_WIDTH  multiplier for mode 10.
- matrixA_in  in  MAX_DIM*MAX_DIM*ELEM_WIDTH  row-major; element (i,j) at bit offset (i*MAX_DIM+j)*ELEM_WIDTH.
- matrixB_in  in  same width  same layout as matrixA_in.
- matrix_out  out  same width  result, same layout.
- out_m  out  DW  result row count.
- out_n  out  DW  result column count.
- busy  out  1  high while an operation is in flight.
- valid  out  1  one-cycle pulse when the result is published.
- err  out  1  one-cycle pulse on a rejected start.

Function
REQ-004 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-005 In IDLE, start=1 with 1<=m<=MAX_DIM and 1<=n<=MAX_DIM SHALL latch m, n, mode, scalar, A and B, clear the internal result buffer, and enter RUN.
REQ-006 In IDLE, start=1 with an illegal m or n SHALL pulse err for 1 cycle, stay in IDLE, and leave matrix_out, out_m and out_n unchanged.
REQ-007 RUN SHALL compute one element per cycle, row-major over i<m, j<n; the index wraps j to 0 and increments i at j=n-1; the last element moves the FSM to DONE.
REQ-008 Latency: for start sampled at edge T, valid SHALL be high during cycle T+m*n+1; busy SHALL be high from T+1 through T+m*n.
REQ-009 DONE SHALL copy the buffer to matrix_out, set out_m/out_n, pulse valid, and return to IDLE on the next edge.
REQ-010 matrix_out SHALL hold its value until the next DONE.
REQ-011 Output slots outside the result dimensions SHALL be zero.
REQ-012 Modes 00, 01 and 10 SHALL give out_m=m and out_n=n; mode 11 SHALL give out_m=n, out_n=m and out(j,i)=A(i,j).
REQ-013 Mode 10 SHALL form the full 2*ELEM_WIDTH product, then reduce it per REQ-018.
REQ-014 start while busy SHALL be ignored, with no effect on the result or err.
REQ-015 Latched operands SHALL be used throughout RUN; input changes after the start edge SHALL have no effect.

Reset
REQ-016 reset=1 SHALL force IDLE and zero matrix_out, out_m, out_n, busy, valid, err and all internal counters and buffers.
REQ-017 reset=1 during RUN SHALL abort the operation with no valid pulse; reset SHALL override a simultaneous start.

Configuration
REQ-018 Macro MATRIX_SAT_EN SHALL control arithmetic overflow:
- Defined: unsigned saturation; add and mul clamp to 2^ELEM_WIDTH-1, sub clamps to 0.
- Undefined: results are taken modulo 2^ELEM_WIDTH (low bits kept).
- Mode 11 is unaffected either way.

Structure
REQ-019 Package matrix_pkg SHALL hold the mode encoding constants, the FSM state typedef, and the default MAX_DIM/ELEM_WIDTH.
REQ-020 A sub-module matrix_elem_alu SHALL implement the combinational per-element operation, including the MATRIX_SAT_EN behaviour; the FSM, counters and buffers stay in the top module.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Defaults, m=2, n=3, mode 00, A all 10, B all 5: valid at T+7; six elements =15, others 0, out_m=2, out_n=3.
- mode 01, A(0,0)=3, B(0,0)=5, m=n=1: result 254 without MATRIX_SAT_EN, 0 with it.
- mode 10, scalar=20, A(0,0)=20: result 144 without MATRIX_SAT_EN, 255 with it.
- mode 11, m=2, n=3, A(i,j)=i*10+j: out(2,1)=12, out_m=3, out_n=2.
- m=0 or n=6 with start: err pulse, no busy, matrix_out unchanged; start pulsed during busy is ignored.
- reset asserted at cycle 3 of a 5x5 run: no valid pulse, all outputs 0; a new start then completes normally at T+26.
